// File: rtl/mag_pkt_pkg.sv
// rtl/mag_pkt_pkg.sv - shared constants and FSM encoding for the magnetometer packet serializer
package mag_pkt_pkg;

  localparam logic [7:0] MAG_TAG   = 8'h4D;
  localparam int         PKT_W     = 80;
  localparam int         PKT_BYTES = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/mag_pkt_fifo.sv
// rtl/mag_pkt_fifo.sv - synchronous record FIFO; push and pop both honoured when full
module mag_pkt_fifo
  import mag_pkt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = PKT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // When full, a same-cycle pop frees the slot the write lands in.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mag_packet_serializer.sv
// rtl/mag_packet_serializer.sv - captures changed magnetometer records and streams them out MSB-first as bytes
// Optional trailing XOR checksum byte enabled by MAG_PKT_CHECKSUM_EN.
module mag_packet_serializer
  import mag_pkt_pkg::*;
#(
  parameter int         DEPTH = 4,
  parameter logic [7:0] TAG   = MAG_TAG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [79:0]                pkt_in,
  input  logic                       byte_ready,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       busy,
  output logic                       overflow
);

`ifdef MAG_PKT_CHECKSUM_EN
  localparam int LAST_IDX = PKT_BYTES;
`else
  localparam int LAST_IDX = PKT_BYTES - 1;
`endif

  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [PKT_W-1:0] sh_q, sh_d;
  logic [3:0]       idx_q, idx_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
`ifdef MAG_PKT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic             new_pkt;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PKT_W-1:0] fifo_dout;

  // Upstream has no strobe: a record is new when its content changes and carries the tag.
  assign new_pkt  = (pkt_in != pkt_q) && (pkt_in[7:0] == TAG);
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  mag_pkt_fifo #(
    .DEPTH (DEPTH),
    .W     (PKT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (new_pkt),
    .pop   (fifo_pop),
    .din   (pkt_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pkt_count)
  );

  always_comb begin
    pkt_d   = pkt_in;
    sh_d    = sh_q;
    idx_d   = idx_q;
    state_d = state_q;
    ovf_d   = ovf_q | (new_pkt && fifo_full && !fifo_pop);
`ifdef MAG_PKT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          sh_d    = fifo_dout;
          idx_d   = '0;
          state_d = SEND;
`ifdef MAG_PKT_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      SEND: begin
        if (byte_ready) begin
          sh_d  = {sh_q[PKT_W-9:0], 8'h00};
          idx_d = idx_q + 1'b1;
`ifdef MAG_PKT_CHECKSUM_EN
          csum_d = csum_q ^ sh_q[PKT_W-1 -: 8];
`endif
          if (idx_q == 4'(LAST_IDX)) begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_q   <= '0;
      sh_q    <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
`ifdef MAG_PKT_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      pkt_q   <= pkt_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
`ifdef MAG_PKT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign overflow   = ovf_q;

`ifdef MAG_PKT_CHECKSUM_EN
  assign byte_out = !byte_valid ? 8'h00 :
                    (idx_q == 4'(PKT_BYTES)) ? csum_q : sh_q[PKT_W-1 -: 8];
`else
  assign byte_out = byte_valid ? sh_q[PKT_W-1 -: 8] : 8'h00;
`endif

endmodule

// File: tb/tb_mag_packet_serializer.sv
// tb/tb_mag_packet_serializer.sv - directed self-checking bench for mag_packet_serializer
module tb_mag_packet_serializer;

`ifdef MAG_PKT_CHECKSUM_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [79:0] pkt_in = '0;
  logic        byte_ready = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [2:0]  pkt_count;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  mag_packet_serializer #(.DEPTH(4), .TAG(8'h4D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_in     (pkt_in),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .pkt_count  (pkt_count),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] pkt;
    logic        capture;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [79:0] p, input int k);
    logic [7:0] x;
    x = 8'h00;
    if (k < 10) return p[79-8*k -: 8];
    for (int i = 0; i < 10; i++) x ^= p[79-8*i -: 8];
    return x;
  endfunction

  // Caller has just changed pkt_in with byte_ready=1 and an idle, empty DUT.
  task automatic stream_check(input string name, input logic [79:0] p);
    tick();
    chk({name, "_lat1_valid"}, 80'(byte_valid), 80'd0);
    chk({name, "_lat1_count"}, 80'(pkt_count), 80'd1);
    tick();
    chk({name, "_lat2_valid"}, 80'(byte_valid), 80'd1);
    chk({name, "_lat2_count"}, 80'(pkt_count), 80'd0);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s_byte%0d", name, k), 80'(byte_out), 80'(exp_byte(p, k)));
      tick();
    end
    chk({name, "_end_valid"}, 80'(byte_valid), 80'd0);
    chk({name, "_end_busy"}, 80'(busy), 80'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        seen;
    logic [79:0] r [6];
    logic [7:0]  got [NB];
    int          ngot;
    int          pat [4];
    int          pi;
    logic        prev_stall;
    logic [7:0]  prev_byte;
    int          total;
    int          wait_cyc;

    vecs[0] = '{80'h112233445566_ABCDEF_4D, 1'b1};
    vecs[1] = '{80'h112233445566_ABCDEF_4D, 1'b0};
    vecs[2] = '{80'hA1B2C3D4E5F6_000102_00, 1'b0};
    vecs[3] = '{80'h010203040506_070809_4D, 1'b1};
    vecs[4] = '{80'hFFFFFFFFFFFF_FFFFFF_4D, 1'b1};

    // Reset state and quiet idle
    repeat (3) tick();
    chk("rst_valid", 80'(byte_valid), 80'd0);
    chk("rst_busy", 80'(busy), 80'd0);
    chk("rst_byte", 80'(byte_out), 80'd0);
    chk("rst_count", 80'(pkt_count), 80'd0);
    chk("rst_ovf", 80'(overflow), 80'd0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (byte_valid) seen = 1'b1;
    end
    chk("idle_no_valid", 80'(seen), 80'd0);
    chk("idle_count", 80'(pkt_count), 80'd0);
    chk("idle_ovf", 80'(overflow), 80'd0);

    // Table-driven records
    byte_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      pkt_in = vecs[v].pkt;
      if (vecs[v].capture) begin
        stream_check($sformatf("vec%0d", v), vecs[v].pkt);
      end else begin
        tick();
        tick();
        chk($sformatf("vec%0d_nocap_count", v), 80'(pkt_count), 80'd0);
        chk($sformatf("vec%0d_nocap_valid", v), 80'(byte_valid), 80'd0);
      end
    end

    // Stalls with byte_ready pattern 1,0,0,1
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    pi = 0;
    ngot = 0;
    prev_stall = 1'b0;
    prev_byte = 8'h00;
    pkt_in = 80'hDEADBEEFCAFE_123456_4D;
    for (int c = 0; c < 80 && ngot < NB; c++) begin
      if (byte_valid) begin
        if (prev_stall) chk($sformatf("stall_hold%0d", ngot), 80'(byte_out), 80'(prev_byte));
        byte_ready = (pat[pi % 4] != 0);
        pi++;
        if (byte_ready) begin
          got[ngot] = byte_out;
          ngot++;
        end
        prev_stall = !byte_ready;
        prev_byte = byte_out;
      end else begin
        byte_ready = 1'b1;
      end
      tick();
    end
    chk("stall_nbytes", 80'(ngot), 80'(NB));
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("stall_byte%0d", k), 80'(got[k]), 80'(exp_byte(80'hDEADBEEFCAFE_123456_4D, k)));
    end
    byte_ready = 1'b1;
    chk("stall_end_valid", 80'(byte_valid), 80'd0);

    // Overflow: six records while downstream is stalled
    byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r[i] = {8'(8'hA0 + i), 40'h0102030405, 24'(24'h000100 + i), 8'h4D};
    end
    for (int i = 0; i < 6; i++) begin
      pkt_in = r[i];
      tick();
    end
    chk("ovf_count", 80'(pkt_count), 80'd4);
    chk("ovf_flag", 80'(overflow), 80'd1);
    chk("ovf_busy", 80'(busy), 80'd1);
    chk("ovf_first_byte", 80'(byte_out), 80'(exp_byte(r[0], 0)));
    repeat (5) tick();
    chk("ovf_sticky", 80'(overflow), 80'd1);
    chk("ovf_count_hold", 80'(pkt_count), 80'd4);
    byte_ready = 1'b1;
    total = 0;
    for (int c = 0; c < 100; c++) begin
      if (byte_valid) begin
        if (total < 5 * NB)
          chk($sformatf("drain_byte%0d", total), 80'(byte_out), 80'(exp_byte(r[total / NB], total % NB)));
        total++;
      end
      tick();
    end
    chk("drain_total", 80'(total), 80'(5 * NB));
    chk("drain_count", 80'(pkt_count), 80'd0);
    chk("drain_ovf_sticky", 80'(overflow), 80'd1);

    // Reset during the 4th byte
    pkt_in = '0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst2_ovf_clear", 80'(overflow), 80'd0);
    pkt_in = 80'h0A0B0C0D0E0F_102030_4D;
    wait_cyc = 0;
    while (!byte_valid && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    chk("rst2_start_valid", 80'(byte_valid), 80'd1);
    repeat (3) tick();
    chk("rst2_byte3", 80'(byte_out), 80'(exp_byte(80'h0A0B0C0D0E0F_102030_4D, 3)));
    #2;
    rst = 1'b0;
    pkt_in = '0;
    #1;
    chk("rst2_async_valid", 80'(byte_valid), 80'd0);
    chk("rst2_async_busy", 80'(busy), 80'd0);
    chk("rst2_async_byte", 80'(byte_out), 80'd0);
    chk("rst2_async_count", 80'(pkt_count), 80'd0);
    chk("rst2_async_ovf", 80'(overflow), 80'd0);
    tick();
    tick();
    rst = 1'b1;
    pkt_in = 80'h5A6B7C8D9EAF_C0FFEE_4D;
    stream_check("after_rst", 80'h5A6B7C8D9EAF_C0FFEE_4D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
